bcd_modn_counter: RTL

//   Parametrised multi-digit BCD modulo-N counter for the clock datapath.

---
 rtl/bcd_modn_counter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bcd_modn_counter.sv
// Multi-digit BCD modulo-N counter with enable, up/down, validated parallel
// load and a same-cycle cascade carry for chaining counters on one clock.
module bcd_modn_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry_out,
    output logic                  count_complete,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] res;
        int           rem;
        res = '0;
        rem = value;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(rem % 10);
            rem           = rem / 10;
        end
        return res;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

    logic [W-1:0] count_q, count_d;
    logic         count_complete_q, count_complete_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         inc_carry;
    logic         dec_borrow;
    logic         digits_ok;
    logic         load_ok;
    logic         at_max;
    logic         at_zero;

    // Ripple the BCD carry/borrow through the digits within a single cycle.
    always_comb begin
        inc_val   = count_q;
        inc_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
        end
    end

    always_comb begin
        dec_val    = count_q;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dec_borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    // With every digit valid, raw binary order equals decimal order,
    // so the range check is a plain compare against MODULUS-1 in BCD.
    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
        load_ok = digits_ok && (load_val <= MAX_BCD);
    end

    assign at_max  = (count_q == MAX_BCD);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d          = count_q;
        count_complete_d = 1'b0;
        load_err_d       = 1'b0;
        if (load) begin
            if (load_ok) begin
                count_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    count_d          = '0;
                    count_complete_d = 1'b1;
                end else begin
                    count_d = inc_val;
                end
            end else begin
                if (at_zero) begin
                    count_d          = MAX_BCD;
                    count_complete_d = 1'b1;
                end else begin
                    count_d = dec_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q          <= '0;
            count_complete_q <= 1'b0;
            load_err_q       <= 1'b0;
        end else begin
            count_q          <= count_d;
            count_complete_q <= count_complete_d;
            load_err_q       <= load_err_d;
        end
    end

    assign count          = count_q;
    assign count_complete = count_complete_q;
    assign load_err       = load_err_q;
    // Drives the next stage's en so it steps on the same edge this one wraps.
    assign carry_out      = en & ~load & (up ? at_max : at_zero);

endmodule
